// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Purpose:
//   Decodes a two-channel quadrature encoder into step pulses and a direction
//   flag for a downstream up/down counter. Both channels are synchronised,
//   then debounced by a per-channel run-length filter. After that, each
//   filtered state change is classified as a step up, a step down or an
//   illegal jump.
//
// Parameters:
//   FILT_LEN   number of consecutive cycles a new synchronised level must be
//              held before the filtered value accepts it (1..15, default 4)
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   reset      synchronous, active-low reset
//   en         enables step/err generation; filtering runs regardless
//   enc_a      asynchronous quadrature channel A
//   enc_b      asynchronous quadrature channel B
//   step       one-cycle pulse per accepted quadrature transition
//   count_dir  direction of the most recent step (1 = up, 0 = down)
//   err        one-cycle pulse when both filtered channels change together
//   err_count  (only with QUAD_ERR_CNT_EN) saturating 8-bit count of err pulses
//
// Configuration:
//   Define QUAD_ERR_CNT_EN to add the err_count output and its counter.
// -----------------------------------------------------------------------------
module quad_step_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic       step,
  output logic       count_dir,
`ifdef QUAD_ERR_CNT_EN
  output logic       err,
  output logic [7:0] err_count
`else
  output logic       err
`endif
);

  // Counter value at which a pending mismatch is accepted on the next edge.
  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic       s1_a, s2_a, s1_b, s2_b;
  logic       filt_a, filt_b;
  logic [3:0] cnt_a, cnt_b;
  logic [1:0] prev_ab;
  logic [1:0] cur_ab;
  logic       is_up, is_down, is_bad;

  assign cur_ab = {filt_a, filt_b};

  // Two-flop synchronisers for both asynchronous channels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_a <= 1'b0;
      s2_a <= 1'b0;
      s1_b <= 1'b0;
      s2_b <= 1'b0;
    end else begin
      s1_a <= enc_a;
      s2_a <= s1_a;
      s1_b <= enc_b;
      s2_b <= s2_b ^ (s2_b ^ s1_b);
    end
  end

  // Channel A filter: the counter measures how long s2 has disagreed with the
  // filtered value, and the new level is taken when that run reaches FILT_LEN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_a <= 1'b0;
      cnt_a  <= 4'd0;
    end else if (s2_a != filt_a) begin
      if (cnt_a == CNT_LAST) begin
        filt_a <= s2_a;
        cnt_a  <= 4'd0;
      end else begin
        cnt_a <= cnt_a + 4'd1;
      end
    end else begin
      cnt_a <= 4'd0;
    end
  end

  // Channel B filter, identical to channel A.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_b <= 1'b0;
      cnt_b  <= 4'd0;
    end else if (s2_b != filt_b) begin
      if (cnt_b == CNT_LAST) begin
        filt_b <= s2_b;
        cnt_b  <= 4'd0;
      end else begin
        cnt_b <= cnt_b + 4'd1;
      end
    end else begin
      cnt_b <= 4'd0;
    end
  end

  // Classify the change from the previous filtered state to the current one.
  // Gray order 00 -> 01 -> 11 -> 10 -> 00 is counting up. A change of both
  // bits at once cannot be a single step, so it is flagged as illegal.
  always_comb begin
    is_up   = 1'b0;
    is_down = 1'b0;
    is_bad  = 1'b0;
    case ({prev_ab, cur_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up   = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_down = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_bad  = 1'b1;
      default: ;
    endcase
  end

  // The previous-state register tracks the filtered value even while en is
  // low. A transition that happened while disabled is therefore absorbed and
  // never replayed when en returns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_ab   <= 2'b00;
      step      <= 1'b0;
      err       <= 1'b0;
      count_dir <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      step    <= en & (is_up | is_down);
      err     <= en & is_bad;
      if (en && (is_up || is_down)) begin
        count_dir <= is_up;
      end
    end
  end

`ifdef QUAD_ERR_CNT_EN
  // Saturating count of err pulses; it follows the registered err output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_step_decoder
//
// Drives quad_step_decoder (FILT_LEN = 4) with directed sequences first and
// then random level changes. A reference model inside the bench predicts each
// step/err event and the cycle it should appear on. It pushes these into a
// scoreboard queue. A monitor running on the falling edge pops an event and
// compares it whenever the DUT pulses step or err. Each cycle the monitor
// also checks count_dir and, when QUAD_ERR_CNT_EN is defined, err_count.
// -----------------------------------------------------------------------------
module tb_quad_step_decoder;

  localparam int FL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;
  logic step, count_dir, err;
`ifdef QUAD_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  quad_step_decoder #(.FILT_LEN(FL)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .step      (step),
    .count_dir (count_dir),
`ifdef QUAD_ERR_CNT_EN
    .err       (err),
    .err_count (err_count)
`else
    .err       (err)
`endif
  );

  typedef struct {
    int cyc;
    bit is_err;
    bit dir;
  } event_t;

  event_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: index 0 is channel A, index 1 is channel B.
  bit       m_s1[2];
  bit       m_s2[2];
  bit       m_filt[2];
  int       m_run[2];
  bit [1:0] m_prev;
  bit       m_dir;
  int       m_ecnt;

  // Position of a state along the up-counting Gray cycle.
  function automatic int gray_pos(bit [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Advance the model by one rising edge, using the inputs sampled at that edge.
  task automatic model_edge(bit r, bit e, bit a, bit b);
    bit [1:0] cur;
    int       d;
    event_t   ev;
    bit       in_v[2];
    in_v[0] = a;
    in_v[1] = b;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_run[i] = 0;
      end
      m_prev = 2'b00;
      m_dir  = 0;
      m_ecnt = 0;
    end else begin
      cur = {m_filt[0], m_filt[1]};
      d = (gray_pos(cur) - gray_pos(m_prev) + 4) % 4;
      if (e && d != 0) begin
        ev.cyc    = cyc;
        ev.is_err = (d == 2);
        ev.dir    = (d == 1);
        if (d == 2) begin
          ev.dir = m_dir;
          if (m_ecnt < 255) m_ecnt++;
        end else begin
          m_dir = (d == 1);
        end
        sb.push_back(ev);
      end
      m_prev = cur;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == FL) begin
            m_filt[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = in_v[i];
      end
    end
  endtask

  // Drive one cycle of stimulus, let the DUT and model see the edge, and
  // return on the following falling edge.
  task automatic applyStimulus(bit r, bit e, bit a, bit b);
    reset = r;
    en    = e;
    enc_a = a;
    enc_b = b;
    @(posedge clk);
    cyc++;
    model_edge(r, e, a, b);
    @(negedge clk);
  endtask

  task automatic hold(bit e, bit a, bit b, int n);
    repeat (n) applyStimulus(1'b1, e, a, b);
  endtask

  // Monitor: every falling edge, check the outputs against the scoreboard.
  always @(negedge clk) begin
    if (cyc > 0) checkOutput();
  end

  task automatic checkOutput();
    event_t ev;
    checks++;
    if (count_dir !== m_dir) begin
      errors++;
      $display("[TB] FAIL count_dir cyc=%0d actual=%b required=%b", cyc, count_dir, m_dir);
    end
    checks++;
    if (step === 1'b1 && err === 1'b1) begin
      errors++;
      $display("[TB] FAIL step_err_exclusive cyc=%0d actual=both_high required=not_both", cyc);
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      ev = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missed_event cyc=%0d actual=none required=%s_at_%0d",
               cyc, ev.is_err ? "err" : "step", ev.cyc);
    end
    if (step !== 1'b0 || err !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse cyc=%0d actual=step%b_err%b required=none",
                 cyc, step, err);
      end else begin
        ev = sb.pop_front();
        if (ev.cyc != cyc || ev.is_err != err || (!ev.is_err && ev.dir != count_dir)) begin
          errors++;
          $display("[TB] FAIL event cyc=%0d actual=step%b_err%b_dir%b required=%s_dir%b_at_%0d",
                   cyc, step, err, count_dir, ev.is_err ? "err" : "step", ev.dir, ev.cyc);
        end
      end
    end
`ifdef QUAD_ERR_CNT_EN
    checks++;
    if (int'(err_count) != m_ecnt) begin
      errors++;
      $display("[TB] FAIL err_count cyc=%0d actual=%0d required=%0d", cyc, err_count, m_ecnt);
    end
`endif
  endtask

  initial begin
    bit a, b, e;
    int n;

    // Hold reset for 3 cycles with both inputs high; no pulses are allowed.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    // After release, 00 -> 11 is a double change and gives one err.
    hold(1'b1, 1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 1'b0, 12);

    // Up sequence, each level held 10 cycles.
    hold(1'b1, 1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 1'b1, 10);
    hold(1'b1, 1'b1, 1'b0, 10);
    hold(1'b1, 1'b0, 1'b0, 10);

    // Down sequence.
    hold(1'b1, 1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 1'b1, 10);
    hold(1'b1, 1'b0, 1'b0, 10);

    // A 3-cycle glitch on A is shorter than the filter, so no event follows.
    hold(1'b1, 1'b1, 1'b0, 3);
    hold(1'b1, 1'b0, 1'b0, 10);

    // Disabled during 00 -> 01; enabling again must not replay that step.
    hold(1'b0, 1'b0, 1'b1, 12);
    hold(1'b1, 1'b0, 1'b1, 5);
    hold(1'b1, 1'b1, 1'b1, 12);

    // Reset partway through a qualification, then a fresh transition.
    hold(1'b1, 1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 1'b1, 12);

    // Adjacent levels held just long enough give back-to-back steps.
    hold(1'b1, 1'b1, 1'b1, FL);
    hold(1'b1, 1'b1, 1'b0, FL);
    hold(1'b1, 1'b0, 1'b0, FL);
    hold(1'b1, 1'b0, 1'b0, 8);

    // Random levels, hold times, enables and occasional resets.
    for (int k = 0; k < 400; k++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) != 0);
      n = $urandom_range(1, 9);
      if ($urandom_range(0, 49) == 0) begin
        applyStimulus(1'b0, e, a, b);
      end else begin
        hold(e, a, b, n);
      end
    end
    hold(1'b1, 1'b0, 1'b0, 12);

`ifdef QUAD_ERR_CNT_EN
    // Repeated double changes drive the error counter into saturation.
    for (int k = 0; k < 160; k++) begin
      hold(1'b1, 1'b1, 1'b1, 6);
      hold(1'b1, 1'b0, 1'b0, 6);
    end
`endif

    // Drain: every predicted event must have been seen by now.
    hold(1'b1, 1'b0, 1'b0, 20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d_pending required=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
